// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, per-item stock and prices, change/refund paid
// one coin at a time. Define VEND_TIMEOUT_EN to refund credit after TIMEOUT_CYC idle cycles.
module vend_ctrl_multi #(
   parameter int unsigned NUM_ITEMS = 4,
   parameter int unsigned CREDIT_W = 8,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TBL = {8'd30, 8'd25, 8'd20, 8'd15},
   parameter int unsigned MAX_CREDIT = 100,
   parameter int unsigned STOCK_W = 4,
   parameter int unsigned STOCK_INIT = 10,
   parameter int unsigned TIMEOUT_CYC = 1000,
   localparam int unsigned IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coin_valid,
   input  logic [4:0]           coin_val,
   output logic                 coin_reject,
   input  logic                 sel_valid,
   input  logic [IDX_W-1:0]     sel_idx,
   output logic                 sel_denied,
   input  logic                 cancel,
   input  logic                 restock,
   output logic                 vend_valid,
   output logic [IDX_W-1:0]     vend_idx,
   input  logic                 vend_ready,
   output logic                 chg_valid,
   output logic [4:0]           chg_coin,
   input  logic                 chg_ready,
   output logic [CREDIT_W-1:0]  credit,
   output logic [NUM_ITEMS-1:0] sold_out,
   output logic                 busy
);

   typedef enum logic [2:0] {StIdle, StCredit, StVend, StChange, StRefund} state_e;

   localparam logic [CREDIT_W:0]  MaxCredit = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0] StockInit = STOCK_W'(STOCK_INIT);

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
   logic                vend_valid_q, vend_valid_d;
   logic [IDX_W-1:0]    vend_idx_q, vend_idx_d;
   logic                chg_valid_q, chg_valid_d;
   logic [4:0]          chg_coin_q, chg_coin_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_denied_q, sel_denied_d;

   logic [CREDIT_W-1:0] price;
   logic [STOCK_W-1:0]  sel_stock;
   logic                sel_in_range, sel_ok, coin_legal, in_shop;
   logic                tmo_hit, do_refund, buy, coin_take;
   logic [CREDIT_W:0]   base, sum;
   logic [CREDIT_W-1:0] rem;

   function automatic logic [4:0] largest_coin(input logic [CREDIT_W-1:0] c);
      logic [4:0] r;
      if (c >= CREDIT_W'(20))      r = 5'd20;
      else if (c >= CREDIT_W'(10)) r = 5'd10;
      else if (c >= CREDIT_W'(5))  r = 5'd5;
      else                         r = 5'd0;
      return r;
   endfunction

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TmoW-1:0] tmo_q;
   logic            activity;

   assign activity = coin_valid | sel_valid | cancel;
   assign tmo_hit  = (state_q == StCredit) && !activity && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

   // Idle-cycle counter, held at zero outside CREDIT so entry always starts a fresh window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
      end else if (state_q != StCredit || activity || tmo_hit) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + TmoW'(1);
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      price        = '0;
      sel_stock    = '0;
      sel_in_range = 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            price        = PRICE_TBL[i*CREDIT_W +: CREDIT_W];
            sel_stock    = stock_q[i];
            sel_in_range = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      stock_d       = stock_q;
      vend_valid_d  = vend_valid_q;
      vend_idx_d    = vend_idx_q;
      chg_valid_d   = chg_valid_q;
      chg_coin_d    = chg_coin_q;
      coin_reject_d = coin_valid;
      sel_denied_d  = 1'b0;

      coin_legal = coin_val inside {5'd5, 5'd10, 5'd20};
      in_shop    = (state_q == StIdle) || (state_q == StCredit);
      sel_ok     = sel_in_range && (sel_stock != '0) && (credit_q >= price);
      do_refund  = (state_q == StCredit) && (cancel || tmo_hit);
      buy        = (state_q == StCredit) && sel_valid && !do_refund && sel_ok;
      // A coin landing with a purchase is judged against the post-purchase credit.
      base       = {1'b0, credit_q} - (buy ? {1'b0, price} : '0);
      sum        = base + (CREDIT_W+1)'(coin_val);
      coin_take  = in_shop && coin_valid && coin_legal && !do_refund && (sum <= MaxCredit);
      rem        = credit_q - CREDIT_W'(chg_coin_q);

      case (state_q)
         StIdle, StCredit: begin
            if (sel_valid && !do_refund && !buy) sel_denied_d = 1'b1;
            if (coin_take) coin_reject_d = 1'b0;
            credit_d = coin_take ? sum[CREDIT_W-1:0] : base[CREDIT_W-1:0];
            if (state_q == StIdle && restock) begin
               for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_d[i] = StockInit;
            end
            if (buy) begin
               for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                  if (sel_idx == IDX_W'(i)) stock_d[i] = stock_q[i] - STOCK_W'(1);
               end
               vend_idx_d = sel_idx;
               state_d    = StVend;
            end else if (do_refund) begin
               chg_valid_d = 1'b1;
               chg_coin_d  = largest_coin(credit_q);
               state_d     = StRefund;
            end else if (coin_take) begin
               state_d = StCredit;
            end
         end
         StVend: begin
            if (!vend_valid_q) begin
               vend_valid_d = 1'b1;
            end else if (vend_ready) begin
               vend_valid_d = 1'b0;
               if (credit_q != '0) begin
                  chg_valid_d = 1'b1;
                  chg_coin_d  = largest_coin(credit_q);
                  state_d     = StChange;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StChange, StRefund: begin
            if (chg_valid_q && chg_ready) begin
               credit_d = rem;
               if (rem == '0) begin
                  chg_valid_d = 1'b0;
                  chg_coin_d  = '0;
                  state_d     = StIdle;
               end else begin
                  chg_coin_d = largest_coin(rem);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= StockInit;
         vend_valid_q  <= 1'b0;
         vend_idx_q    <= '0;
         chg_valid_q   <= 1'b0;
         chg_coin_q    <= '0;
         coin_reject_q <= 1'b0;
         sel_denied_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         stock_q       <= stock_d;
         vend_valid_q  <= vend_valid_d;
         vend_idx_q    <= vend_idx_d;
         chg_valid_q   <= chg_valid_d;
         chg_coin_q    <= chg_coin_d;
         coin_reject_q <= coin_reject_d;
         sel_denied_q  <= sel_denied_d;
      end
   end

   always_comb begin
      sold_out = '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
   end

   assign coin_reject = coin_reject_q;
   assign sel_denied  = sel_denied_q;
   assign vend_valid  = vend_valid_q;
   assign vend_idx    = vend_idx_q;
   assign chg_valid   = chg_valid_q;
   assign chg_coin    = chg_coin_q;
   assign credit      = credit_q;
   assign busy        = (state_q == StVend) || (state_q == StChange) || (state_q == StRefund);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: transaction-level vending model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_vend_ctrl_multi;

   localparam int N   = 4;
   localparam int TMO = 8;
`ifdef VEND_TIMEOUT_EN
   localparam bit TmoOn = 1'b1;
`else
   localparam bit TmoOn = 1'b0;
`endif

   logic       clk, rst;
   logic       coin_valid, sel_valid, cancel, restock, vend_ready, chg_ready;
   logic [4:0] coin_val;
   logic [1:0] sel_idx;
   logic       coin_reject, sel_denied, vend_valid, chg_valid, busy;
   logic [1:0] vend_idx;
   logic [4:0] chg_coin;
   logic [7:0] credit;
   logic [3:0] sold_out;

   vend_ctrl_multi #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .coin_valid(coin_valid), .coin_val(coin_val), .coin_reject(coin_reject),
      .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_denied(sel_denied),
      .cancel(cancel), .restock(restock),
      .vend_valid(vend_valid), .vend_idx(vend_idx), .vend_ready(vend_ready),
      .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
      .credit(credit), .sold_out(sold_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a sale is a phase plus a queue of coins still owed to the customer.
   typedef enum int {PhIdle, PhCredit, PhVend, PhPay} ph_e;
   ph_e m_ph;
   int  m_credit, m_vidx, m_idle;
   int  m_stock[N];
   int  m_pay[$];
   bit  m_vend_on, e_rej, e_den;

   function automatic int price_of(input int i);
      return 15 + 5 * i;
   endfunction

   task automatic start_payout();
      int c = m_credit;
      m_pay.delete();
      while (c > 0) begin
         int k;
         k = (c >= 20) ? 20 : (c >= 10) ? 10 : 5;
         m_pay.push_back(k);
         c -= k;
      end
      m_ph = PhPay;
   endtask

   task automatic model_reset();
      m_ph = PhIdle;
      m_credit = 0;
      m_vidx = 0;
      m_idle = 0;
      m_vend_on = 0;
      e_rej = 0;
      e_den = 0;
      m_pay.delete();
      for (int i = 0; i < N; i++) m_stock[i] = 10;
   endtask

   task automatic model_step();
      ph_e old;
      bit  legal, evt, refund, buy, take;
      int  base;
      old   = m_ph;
      legal = (coin_val == 5) || (coin_val == 10) || (coin_val == 20);
      evt   = coin_valid || sel_valid || cancel;
      e_rej = coin_valid;
      e_den = 0;
      case (m_ph)
         PhIdle, PhCredit: begin
            refund = (m_ph == PhCredit) && (cancel || (TmoOn && !evt && m_idle == TMO - 1));
            buy = 0;
            if (sel_valid && !refund) begin
               if (m_ph == PhCredit && m_stock[sel_idx] > 0 && m_credit >= price_of(int'(sel_idx)))
                  buy = 1;
               else
                  e_den = 1;
            end
            base = buy ? m_credit - price_of(int'(sel_idx)) : m_credit;
            take = coin_valid && legal && !refund && (base + int'(coin_val) <= 100);
            if (take) e_rej = 0;
            m_credit = base + (take ? int'(coin_val) : 0);
            if (old == PhIdle && restock) for (int i = 0; i < N; i++) m_stock[i] = 10;
            if (buy) begin
               m_stock[sel_idx]--;
               m_vidx = int'(sel_idx);
               m_vend_on = 0;
               m_ph = PhVend;
            end else if (refund) begin
               start_payout();
            end else if (m_credit > 0) begin
               m_ph = PhCredit;
            end
         end
         PhVend: begin
            if (!m_vend_on) m_vend_on = 1;
            else if (vend_ready) begin
               m_vend_on = 0;
               if (m_credit > 0) start_payout();
               else m_ph = PhIdle;
            end
         end
         PhPay: begin
            if (chg_ready) begin
               m_credit -= m_pay.pop_front();
               if (m_pay.size() == 0) m_ph = PhIdle;
            end
         end
         default: m_ph = PhIdle;
      endcase
      if (m_ph == PhCredit && old == PhCredit && !evt) m_idle++;
      else m_idle = 0;
   endtask

   task automatic compare();
      logic [3:0] exp_so;
      for (int i = 0; i < N; i++) exp_so[i] = (m_stock[i] == 0);
      check("coin_reject", 32'(coin_reject), 32'(e_rej));
      check("sel_denied", 32'(sel_denied), 32'(e_den));
      check("vend_valid", 32'(vend_valid), 32'(m_vend_on));
      check("vend_idx", 32'(vend_idx), m_vidx);
      check("chg_valid", 32'(chg_valid), 32'(m_ph == PhPay));
      check("chg_coin", 32'(chg_coin), (m_ph == PhPay) ? m_pay[0] : 0);
      check("credit", 32'(credit), m_credit);
      check("sold_out", 32'(sold_out), 32'(exp_so));
      check("busy", 32'(busy), 32'(m_ph == PhVend || m_ph == PhPay));
   endtask

   always @(posedge clk) if (rst) model_step();
   always @(negedge rst) model_reset();
   always @(negedge clk) compare();

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      coin_valid = 0; coin_val = 0; sel_valid = 0; sel_idx = 0;
      cancel = 0; restock = 0; vend_ready = 0; chg_ready = 0;
   endtask

   task automatic coin(input int v);
      coin_valid = 1; coin_val = 5'(v);
      cyc();
      coin_valid = 0;
   endtask

   task automatic select(input int i);
      sel_valid = 1; sel_idx = 2'(i);
      cyc();
      sel_valid = 0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (m_ph != PhIdle && k < budget) begin
         cyc();
         k++;
      end
      n_chk++;
      if (m_ph != PhIdle) begin
         n_fail++;
         $display("FAIL wait_idle: model still busy after %0d cycles", budget);
      end
   endtask

   task automatic refund_now();
      cancel = 1; chg_ready = 1;
      cyc();
      cancel = 0;
      wait_idle(20);
      chg_ready = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int r;
      model_reset();
      idle_inputs();
      rst = 0;
      repeat (3) cyc();
      check("rst_credit", 32'(credit), 0);
      check("rst_sold_out", 32'(sold_out), 0);
      rst = 1;
      cyc();

      // Buy item 0 with 20 credit: one 5 coin change.
      coin(10); coin(10);
      select(0);
      check("buy_credit", 32'(credit), 5);
      check("buy_vv_early", 32'(vend_valid), 0);
      cyc();
      check("buy_vv", 32'(vend_valid), 1);
      check("buy_vidx", 32'(vend_idx), 0);
      vend_ready = 1;
      cyc();
      vend_ready = 0;
      check("chg_first", 32'(chg_coin), 5);
      chg_ready = 1;
      cyc();
      chg_ready = 0;
      check("chg_done_valid", 32'(chg_valid), 0);
      check("chg_done_credit", 32'(credit), 0);
      check("model_stock0", 32'(m_stock[0]), 9);

      // Refund 50 as 20, 20, 10.
      coin(20); coin(20); coin(10);
      cancel = 1; chg_ready = 1;
      cyc();
      cancel = 0;
      check("refund_c0", 32'(chg_coin), 20);
      cyc();
      check("refund_c1", 32'(chg_coin), 20);
      cyc();
      check("refund_c2", 32'(chg_coin), 10);
      cyc();
      chg_ready = 0;
      check("refund_end", 32'(chg_valid), 0);
      check("refund_busy", 32'(busy), 0);

      // Denied selection, illegal coin.
      coin(10);
      select(3);
      check("deny_pulse", 32'(sel_denied), 1);
      check("deny_credit", 32'(credit), 10);
      coin(7);
      check("bad_coin", 32'(coin_reject), 1);
      check("bad_coin_credit", 32'(credit), 10);
      refund_now();

      // Credit ceiling, then coins rejected while a vend stalls.
      coin(20); coin(20); coin(20); coin(20); coin(10); coin(5);
      check("ceil_credit", 32'(credit), 95);
      coin(10);
      check("ceil_reject", 32'(coin_reject), 1);
      check("ceil_hold", 32'(credit), 95);
      select(0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin coin_valid = 1; coin_val = 5; end
         cyc();
         coin_valid = 0;
         check("stall_vv", 32'(vend_valid), 1);
         if (k == 2) check("vend_coin_rej", 32'(coin_reject), 1);
      end
      vend_ready = 1; chg_ready = 1;
      cyc();
      vend_ready = 0;
      wait_idle(20);
      chg_ready = 0;
      check("stall_credit", 32'(credit), 0);

      // Sell out item 1, then restock.
      for (int k = 0; k < 10; k++) begin
         coin(20);
         select(1);
         vend_ready = 1;
         wait_idle(10);
         vend_ready = 0;
      end
      check("soldout1", 32'(sold_out[1]), 1);
      check("model_stock1", 32'(m_stock[1]), 0);
      coin(20);
      select(1);
      check("soldout_deny", 32'(sel_denied), 1);
      refund_now();
      restock = 1;
      cyc();
      restock = 0;
      check("restock_so1", 32'(sold_out[1]), 0);
      check("model_restock", 32'(m_stock[1]), 10);

      // Asynchronous reset in the middle of change.
      coin(20); coin(20);
      select(0);
      vend_ready = 1;
      cyc(); cyc();
      vend_ready = 0;
      check("pre_rst_chg", 32'(chg_coin), 20);
      #2 rst = 0;
      #1;
      check("arst_chg_valid", 32'(chg_valid), 0);
      check("arst_credit", 32'(credit), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_chg_coin", 32'(chg_coin), 0);
      cyc(); cyc();
      rst = 1;
      cyc();
      check("post_rst_credit", 32'(credit), 0);
      check("post_rst_busy", 32'(busy), 0);

`ifdef VEND_TIMEOUT_EN
      coin(5);
      repeat (7) cyc();
      check("tmo_not_yet", 32'(chg_valid), 0);
      cyc();
      check("tmo_refund", 32'(chg_valid), 1);
      check("tmo_coin", 32'(chg_coin), 5);
      chg_ready = 1;
      wait_idle(5);
      chg_ready = 0;
`endif

      for (int c = 0; c < 4000; c++) begin
         coin_valid = ($urandom_range(0, 99) < 30);
         r = $urandom_range(0, 9);
         coin_val = (r < 3) ? 5'd5 : (r < 6) ? 5'd10 : (r < 9) ? 5'd20 : 5'($urandom_range(0, 31));
         sel_valid = ($urandom_range(0, 99) < 15);
         sel_idx = 2'($urandom_range(0, 3));
         cancel = ($urandom_range(0, 99) < 3);
         restock = ($urandom_range(0, 99) < 5);
         vend_ready = ($urandom_range(0, 99) < 50);
         chg_ready = ($urandom_range(0, 99) < 60);
         cyc();
      end
      idle_inputs();
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
